pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/freeze controller for a 5-stage core.
// Revision 1.0 - initial release.
`default_nettype none

module pipe_hazard_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_wn,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        busy,
  output logic        mem_err,
  output logic [15:0] stall_cycles
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_next_cnt;
  logic        r_mem_err;
  logic [15:0] r_stall_cycles;
  logic        w_frozen;
  logic        w_set_err;
  logic        w_load_use;

  assign w_load_use = ex_mem_read && (ex_wn != 5'd0) &&
                      ((ex_wn == id_rs) || (ex_wn == id_rt));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_wait_cnt     <= 8'd0;
      r_mem_err      <= 1'b0;
      r_stall_cycles <= 16'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_cnt;
      if (w_set_err)
        r_mem_err <= 1'b1;
      if (!pc_en && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_wait_cnt;
    w_frozen     = 1'b0;
    w_set_err    = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;

    case (r_state)
      RUN: begin
        if (mem_req && !dmem_ready) begin
          w_frozen     = 1'b1;
          w_next_state = MEM_WAIT;
          w_next_cnt   = 8'd1;
        end
      end
      MEM_WAIT: begin
        // A release cycle (ready or timeout) ignores mem_req entirely.
        if (dmem_ready) begin
          w_next_state = RUN;
          w_next_cnt   = 8'd0;
        end else if (r_wait_cnt < TIMEOUT) begin
          w_frozen   = 1'b1;
          w_next_cnt = r_wait_cnt + 8'd1;
        end else begin
          w_set_err    = 1'b1;
          w_next_state = RUN;
          w_next_cnt   = 8'd0;
        end
      end
      default: begin
        w_next_state = RUN;
        w_next_cnt   = 8'd0;
      end
    endcase

    if (rst || w_frozen) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign busy         = (r_state == MEM_WAIT);
  assign mem_err      = r_mem_err;
  assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: randomized + directed bench with a cycle-level behavioural model.
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_wn = '0;
  logic        ex_mem_read = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, dmem_ready = 1'b0;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic        busy, mem_err;
  logic [15:0] stall_cycles;
  logic [6:0]  w_out;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_hazard_ctrl #(.TIMEOUT(8'(TO))) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_wn(ex_wn), .branch_taken(branch_taken),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .busy(busy), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign w_out = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  function automatic logic [6:0] exp_out(input bit r, input bit frz, input bit br, input bit lu);
    if (r || frz) return 7'b0000000;
    if (br)       return 7'b1111111;
    if (lu)       return 7'b0011101;
    return 7'b1111100;
  endfunction

  // Model: m_frozen = frozen cycles spent so far on the outstanding access (0 = none).
  int m_frozen = 0;
  bit m_err    = 0;
  int m_stall  = 0;
  bit m_valid  = 0;

  always @(negedge clk) begin
    bit frz, rel_err, lu;
    logic [6:0] e;
    frz     = 0;
    rel_err = 0;
    lu = ex_mem_read && (ex_wn != 0) && (ex_wn == id_rs || ex_wn == id_rt);
    if (m_frozen > 0) begin
      if (!dmem_ready) begin
        if (m_frozen == TO) rel_err = 1;
        else                frz = 1;
      end
    end else begin
      frz = mem_req && !dmem_ready;
    end
    e = exp_out(rst, frz, branch_taken, lu);
    chk("model_enables_flushes", 32'(w_out), 32'(e));
    if (m_valid) begin
      chk("model_busy", 32'(busy), 32'(m_frozen > 0));
      chk("model_mem_err", 32'(mem_err), 32'(m_err));
      chk("model_stall_cycles", 32'(stall_cycles), 32'(m_stall));
    end
    if (rst) begin
      m_frozen = 0;
      m_err    = 0;
      m_stall  = 0;
      m_valid  = 1;
    end else if (m_valid) begin
      m_frozen = frz ? m_frozen + 1 : 0;
      if (rel_err) m_err = 1;
      if (!e[6] && m_stall < 65535) m_stall++;
    end
  end

  // Inputs change 1 time unit after posedge; directed checks sample 4 units later.
  task automatic drive(input bit r, input bit mr, input logic [4:0] wn, input logic [4:0] rs,
                       input logic [4:0] rt, input bit br, input bit mq, input bit rdy);
    @(posedge clk);
    #1;
    rst = r; ex_mem_read = mr; ex_wn = wn; id_rs = rs; id_rt = rt;
    branch_taken = br; mem_req = mq; dmem_ready = rdy;
    #3;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_id_ex_en", 32'(id_ex_en), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_pc_en", 32'(pc_en), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_stall", 32'(stall_cycles), 32'd0);

    drive(0, 1, 5, 5, 0, 0, 0, 0);
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_if_id_en", 32'(if_id_en), 32'd0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    chk("lu_id_ex_en", 32'(id_ex_en), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_stall_cycles", 32'(stall_cycles), 32'd1);

    drive(0, 1, 0, 0, 0, 0, 0, 0);
    chk("r0_pc_en", 32'(pc_en), 32'd1);
    chk("r0_id_ex_flush", 32'(id_ex_flush), 32'd0);
    drive(0, 1, 5, 3, 5, 1, 0, 0);
    chk("br_if_id_flush", 32'(if_id_flush), 32'd1);
    chk("br_id_ex_flush", 32'(id_ex_flush), 32'd1);
    chk("br_pc_en", 32'(pc_en), 32'd1);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      chk("mw_pc_en", 32'(pc_en), 32'd0);
      chk("mw_busy", 32'(busy), 32'(i > 0));
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("mw_release_pc_en", 32'(pc_en), 32'd1);
    chk("mw_release_busy", 32'(busy), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mw_after_busy", 32'(busy), 32'd0);
    chk("mw_after_mem_err", 32'(mem_err), 32'd0);
    chk("mw_after_stall", 32'(stall_cycles), 32'd3);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      chk("to_frozen_pc_en", 32'(pc_en), 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("to_release_pc_en", 32'(pc_en), 32'd1);
    chk("to_release_mem_wb_en", 32'(mem_wb_en), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("to_mem_err", 32'(mem_err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_stall", 32'(stall_cycles), 32'd4);

    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("rmw_busy", 32'(busy), 32'd1);
    chk("rmw_mem_err_sticky", 32'(mem_err), 32'd1);
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    chk("rmw_rst_pc_en", 32'(pc_en), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rmw_busy_cleared", 32'(busy), 32'd0);
    chk("rmw_stall_cleared", 32'(stall_cycles), 32'd0);
    chk("rmw_mem_err_cleared", 32'(mem_err), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(199) == 0), ($urandom_range(1) == 1),
            5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
            ($urandom_range(7) == 0), ($urandom_range(3) == 0), ($urandom_range(1) == 1));
    end

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) drive(0, 1, 7, 7, 0, 0, 0, 0);
    chk("sat_stall", 32'(stall_cycles), 32'hFFFF);
    drive(0, 1, 7, 0, 7, 0, 0, 0);
    chk("sat_pc_en", 32'(pc_en), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_stall_held", 32'(stall_cycles), 32'hFFFF);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
